hs_npu_output_packer: RTL

HS_NPU_OUTPUT_PACKER -- requirements
Module: hs_npu_output_packer

---
 rtl/hs_npu_output_packer_if.sv | 29 ++
 rtl/hs_npu_output_packer.sv | 97 +++++++++
 2 files changed

// File: rtl/hs_npu_output_packer_if.sv
// Element-in / packed-word-out handshake bundle for the NPU output packer.
// The slave modport is the packer itself; the master modport is whoever drives it.
interface hs_npu_output_packer_if #(
    parameter int unsigned ELEM_WIDTH     = 16,
    parameter int unsigned ELEMS_PER_WORD = 4
);
    localparam int unsigned WordWidth = ELEM_WIDTH * ELEMS_PER_WORD;
    localparam int unsigned CntWidth  = $clog2(ELEMS_PER_WORD + 1);

    logic [ELEM_WIDTH-1:0] data_i;
    logic                  valid_i;
    logic                  last_i;
    logic                  ready_o;
    logic [WordWidth-1:0]  word_o;
    logic [CntWidth-1:0]   count_o;
    logic                  last_o;
    logic                  valid_o;
    logic                  ready_i;

    modport slave (
        input  data_i, valid_i, last_i, ready_i,
        output ready_o, word_o, count_o, last_o, valid_o
    );

    modport master (
        output data_i, valid_i, last_i, ready_i,
        input  ready_o, word_o, count_o, last_o, valid_o
    );
endinterface

// File: rtl/hs_npu_output_packer.sv
// Packs a stream of activation elements into wide words and buffers closed words in a small
// FIFO. A word closes when it is full or when its element carries last_i.
module hs_npu_output_packer #(
    parameter int unsigned ELEM_WIDTH     = 16,
    parameter int unsigned ELEMS_PER_WORD = 4,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input logic                   clk_i,
    input logic                   rst_ni,
    hs_npu_output_packer_if.slave bus
);
    localparam int unsigned WordWidth = ELEM_WIDTH * ELEMS_PER_WORD;
    localparam int unsigned CntWidth  = $clog2(ELEMS_PER_WORD + 1);
    localparam int unsigned IdxWidth  = $clog2(ELEMS_PER_WORD);
    localparam int unsigned PtrWidth  = $clog2(FIFO_DEPTH);
    localparam int unsigned OccWidth  = $clog2(FIFO_DEPTH + 1);

    logic [IdxWidth-1:0]  r_idx;
    logic [WordWidth-1:0] r_part;
    logic [WordWidth-1:0] r_mem_word [FIFO_DEPTH];
    logic [CntWidth-1:0]  r_mem_cnt  [FIFO_DEPTH];
    logic                 r_mem_last [FIFO_DEPTH];
    logic [PtrWidth-1:0]  r_wptr;
    logic [PtrWidth-1:0]  r_rptr;
    logic [OccWidth-1:0]  r_occ;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_accept;
    logic                 w_close;
    logic                 w_pop;
    logic [WordWidth-1:0] w_word;
    logic [CntWidth-1:0]  w_cnt;

    // ready_o depends only on registered occupancy, so a pop cannot free a slot the same cycle.
    assign w_full      = (r_occ == OccWidth'(FIFO_DEPTH));
    assign w_empty     = (r_occ == '0);
    assign bus.ready_o = !w_full;
    assign w_accept    = bus.valid_i && !w_full;
    assign w_close     = w_accept && (bus.last_i || (r_idx == IdxWidth'(ELEMS_PER_WORD - 1)));
    assign w_pop       = !w_empty && bus.ready_i;
    assign w_cnt       = CntWidth'(r_idx) + CntWidth'(1);

    always_comb begin
        w_word = r_part;
        w_word[r_idx*ELEM_WIDTH +: ELEM_WIDTH] = bus.data_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_idx  <= '0;
            r_part <= '0;
        end else if (w_accept) begin
            if (w_close) begin
                r_idx  <= '0;
                r_part <= '0;
            end else begin
                r_idx  <= r_idx + IdxWidth'(1);
                r_part <= w_word;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_occ  <= '0;
        end else begin
            if (w_close) begin
                r_wptr <= r_wptr + PtrWidth'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PtrWidth'(1);
            end
            case ({w_close, w_pop})
                2'b10:   r_occ <= r_occ + OccWidth'(1);
                2'b01:   r_occ <= r_occ - OccWidth'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Storage needs no reset: every read is masked by the occupancy counter.
    always_ff @(posedge clk_i) begin
        if (w_close) begin
            r_mem_word[r_wptr] <= w_word;
            r_mem_cnt[r_wptr]  <= w_cnt;
            r_mem_last[r_wptr] <= bus.last_i;
        end
    end

    assign bus.valid_o = !w_empty;
    assign bus.word_o  = w_empty ? '0 : r_mem_word[r_rptr];
    assign bus.count_o = w_empty ? '0 : r_mem_cnt[r_rptr];
    assign bus.last_o  = !w_empty && r_mem_last[r_rptr];
endmodule
